// File: rtl/ysyx_exec_ctrl.sv
// ysyx_exec_ctrl: multi-cycle RV32 phase sequencer; YSYX_EXEC_CTRL_PERF_EN adds cycle/instret counters
module ysyx_exec_ctrl #(
    parameter int MEM_TIMEOUT = 255,
    parameter int TW_W        = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        ifu_req,
    input  logic        ifu_rvalid,
    input  logic        ifu_err,
    output logic        inst_we,
    input  logic        dec_rf_wr_en,
    input  logic        dec_csr_wr_en,
    input  logic        dec_is_ecall,
    input  logic        dec_is_mret,
    input  logic        dec_is_ebreak,
    input  logic [2:0]  dec_dm_rd_sel,
    input  logic [1:0]  dec_dm_wr_sel,
    output logic        lsu_req,
    output logic        lsu_we,
    input  logic        lsu_rvalid,
    input  logic        lsu_err,
    output logic        rf_we,
    output logic        csr_we,
    output logic        pc_we,
    output logic [1:0]  pc_sel,
    output logic        trap_we,
    output logic        halt,
    output logic        err,
    output logic [63:0] perf_cycle,
    output logic [63:0] perf_instret
);
    typedef enum logic [2:0] {RST, FETCH, DECODE, MEM, WB, TRAP, HALT, ERR} state_e;
    state_e state_q, state_d;
    logic [TW_W-1:0] cnt_q, cnt_d;
    logic is_mem, timeout;
    assign is_mem  = (dec_dm_rd_sel != 3'd0) || (dec_dm_wr_sel != 2'd0);
    // the cycle where one more unanswered wait would reach the limit
    assign timeout = cnt_q == TW_W'(MEM_TIMEOUT - 1);
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            RST: begin
                state_d = FETCH;
                cnt_d   = '0;
            end
            FETCH: begin
                state_d = ifu_err ? ERR : ifu_rvalid ? DECODE : timeout ? ERR : FETCH;
                cnt_d   = cnt_q + 1'b1;
            end
            DECODE: begin
                state_d = dec_is_ebreak ? HALT : dec_is_ecall ? TRAP : is_mem ? MEM : WB;
                cnt_d   = '0;
            end
            MEM: begin
                state_d = lsu_err ? ERR : lsu_rvalid ? WB : timeout ? ERR : MEM;
                cnt_d   = cnt_q + 1'b1;
            end
            WB, TRAP: begin
                state_d = FETCH;
                cnt_d   = '0;
            end
            default: state_d = state_q;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RST;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end
    assign ifu_req = state_q == FETCH;
    assign inst_we = ifu_req && ifu_rvalid && !ifu_err;
    assign lsu_req = state_q == MEM;
    assign lsu_we  = lsu_req && (dec_dm_wr_sel != 2'd0);
    assign rf_we   = (state_q == WB) && dec_rf_wr_en;
    assign csr_we  = (state_q == WB) && dec_csr_wr_en;
    assign trap_we = state_q == TRAP;
    assign pc_we   = (state_q == WB) || trap_we;
    assign pc_sel  = trap_we ? 2'b01 : ((state_q == WB) && dec_is_mret) ? 2'b10 : 2'b00;
    assign halt    = state_q == HALT;
    assign err     = state_q == ERR;
`ifdef YSYX_EXEC_CTRL_PERF_EN
    logic [63:0] cyc_q, cyc_d, ret_q, ret_d;
    always_comb begin
        cyc_d = (state_q inside {RST, HALT, ERR}) ? cyc_q : cyc_q + 64'd1;
        ret_d = pc_we ? ret_q + 64'd1 : ret_q;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc_q <= '0;
            ret_q <= '0;
        end else begin
            cyc_q <= cyc_d;
            ret_q <= ret_d;
        end
    end
    assign perf_cycle   = cyc_q;
    assign perf_instret = ret_q;
`else
    assign perf_cycle   = '0;
    assign perf_instret = '0;
`endif
endmodule

// File: tb/tb_ysyx_exec_ctrl.sv
// tb_ysyx_exec_ctrl: directed checks of phase strobes, timeouts, halt/err and reset abort
module tb_ysyx_exec_ctrl;
    logic clk = 1'b0, rst_n = 1'b0;
    logic ifu_req, ifu_rvalid, ifu_err, inst_we;
    logic dec_rf_wr_en, dec_csr_wr_en, dec_is_ecall, dec_is_mret, dec_is_ebreak;
    logic [2:0] dec_dm_rd_sel;
    logic [1:0] dec_dm_wr_sel, pc_sel;
    logic lsu_req, lsu_we, lsu_rvalid, lsu_err;
    logic rf_we, csr_we, pc_we, trap_we, halt, err;
    logic [63:0] perf_cycle, perf_instret;
    int n_run = 0, n_fail = 0;
    logic [11:0] ov;
    assign ov = {ifu_req, inst_we, lsu_req, lsu_we, rf_we, csr_we, pc_we, pc_sel, trap_we, halt, err};

    ysyx_exec_ctrl #(.MEM_TIMEOUT(4), .TW_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .ifu_req(ifu_req), .ifu_rvalid(ifu_rvalid), .ifu_err(ifu_err),
        .inst_we(inst_we), .dec_rf_wr_en(dec_rf_wr_en), .dec_csr_wr_en(dec_csr_wr_en),
        .dec_is_ecall(dec_is_ecall), .dec_is_mret(dec_is_mret), .dec_is_ebreak(dec_is_ebreak),
        .dec_dm_rd_sel(dec_dm_rd_sel), .dec_dm_wr_sel(dec_dm_wr_sel), .lsu_req(lsu_req),
        .lsu_we(lsu_we), .lsu_rvalid(lsu_rvalid), .lsu_err(lsu_err), .rf_we(rf_we),
        .csr_we(csr_we), .pc_we(pc_we), .pc_sel(pc_sel), .trap_we(trap_we), .halt(halt),
        .err(err), .perf_cycle(perf_cycle), .perf_instret(perf_instret)
    );

    always #5 clk = ~clk;

    // output vector order: ifu_req inst_we lsu_req lsu_we rf_we csr_we pc_we pc_sel[1:0] trap_we halt err
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cv(input string tag, input logic [11:0] exp);
        #1 chk(tag, {52'd0, ov}, {52'd0, exp});
    endtask

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic clr;
        {ifu_rvalid, ifu_err, lsu_rvalid, lsu_err} = '0;
        {dec_rf_wr_en, dec_csr_wr_en, dec_is_ecall, dec_is_mret, dec_is_ebreak} = '0;
        dec_dm_rd_sel = 3'd0;
        dec_dm_wr_sel = 2'd0;
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        clr();
        cv("rst_asserted", 12'b0000_0000_0000);
        tick();
        rst_n = 1'b1;
        cv("rst_released", 12'b0000_0000_0000);
    endtask

    initial begin
        clr();
        do_reset();
        // ALU op, zero-wait fetch
        tick(); ifu_rvalid = 1; dec_rf_wr_en = 1; cv("alu_fetch", 12'b1100_0000_0000);
        tick(); ifu_rvalid = 0; cv("alu_decode", 12'b0000_0000_0000);
        tick(); cv("alu_wb", 12'b0000_1010_0000);
        tick(); cv("alu_next_fetch", 12'b1000_0000_0000);
        // load, response on 4th MEM cycle (the timeout limit cycle)
        ifu_rvalid = 1; dec_dm_rd_sel = 3'd5; cv("ld_fetch", 12'b1100_0000_0000);
        tick(); ifu_rvalid = 0; cv("ld_decode", 12'b0000_0000_0000);
        tick(); cv("ld_mem1", 12'b0010_0000_0000);
        tick(); cv("ld_mem2", 12'b0010_0000_0000);
        tick(); cv("ld_mem3", 12'b0010_0000_0000);
        tick(); lsu_rvalid = 1; cv("ld_mem4_limit", 12'b0010_0000_0000);
        tick(); lsu_rvalid = 0; cv("ld_wb", 12'b0000_1010_0000);
        // store
        tick(); clr(); ifu_rvalid = 1; dec_dm_wr_sel = 2'd3; cv("st_fetch", 12'b1100_0000_0000);
        tick(); ifu_rvalid = 0; cv("st_decode", 12'b0000_0000_0000);
        tick(); lsu_rvalid = 1; cv("st_mem", 12'b0011_0000_0000);
        tick(); lsu_rvalid = 0; cv("st_wb", 12'b0000_0010_0000);
        // ecall
        tick(); clr(); ifu_rvalid = 1; dec_is_ecall = 1; cv("ecall_fetch", 12'b1100_0000_0000);
        tick(); ifu_rvalid = 0; cv("ecall_decode", 12'b0000_0000_0000);
        tick(); cv("ecall_trap", 12'b0000_0010_1100);
        // mret with csr write
        tick(); clr(); cv("trap_to_fetch", 12'b1000_0000_0000);
        ifu_rvalid = 1; dec_is_mret = 1; dec_csr_wr_en = 1;
        tick(); ifu_rvalid = 0; cv("mret_decode", 12'b0000_0000_0000);
        tick(); cv("mret_wb", 12'b0000_0111_0000);
        // reset pulsed during MEM
        tick(); clr(); ifu_rvalid = 1; dec_dm_rd_sel = 3'd2;
        tick(); ifu_rvalid = 0;
        tick(); cv("abort_mem", 12'b0010_0000_0000);
        rst_n = 0; cv("abort_rst_drop", 12'b0000_0000_0000);
        do_reset();
        tick(); cv("abort_refetch", 12'b1000_0000_0000);
        // two ALU ops for the perf counters
        ifu_rvalid = 1; dec_rf_wr_en = 1;
        tick(); ifu_rvalid = 0;
        tick(); cv("perf_alu1_wb", 12'b0000_1010_0000);
        tick(); ifu_rvalid = 1;
        tick(); ifu_rvalid = 0;
        tick(); cv("perf_alu2_wb", 12'b0000_1010_0000);
        tick();
`ifdef YSYX_EXEC_CTRL_PERF_EN
        chk("perf_instret", perf_instret, 64'd2);
        chk("perf_cycle", perf_cycle, 64'd6);
`else
        chk("perf_instret_off", perf_instret, 64'd0);
        chk("perf_cycle_off", perf_cycle, 64'd0);
`endif
        // ebreak -> sticky halt
        clr(); ifu_rvalid = 1; dec_is_ebreak = 1;
        tick(); ifu_rvalid = 0; cv("ebreak_decode", 12'b0000_0000_0000);
        tick(); cv("halt1", 12'b0000_0000_0010);
        tick(); ifu_rvalid = 1; lsu_rvalid = 1; cv("halt2", 12'b0000_0000_0010);
        tick(); cv("halt3", 12'b0000_0000_0010);
`ifdef YSYX_EXEC_CTRL_PERF_EN
        chk("perf_cycle_frozen", perf_cycle, 64'd8);
`else
        chk("perf_cycle_frozen_off", perf_cycle, 64'd0);
`endif
        // fetch timeout after 4 wait cycles
        do_reset();
        tick(); cv("to_w1", 12'b1000_0000_0000);
        tick(); cv("to_w2", 12'b1000_0000_0000);
        tick(); cv("to_w3", 12'b1000_0000_0000);
        tick(); cv("to_w4", 12'b1000_0000_0000);
        tick(); cv("to_err", 12'b0000_0000_0001);
        tick(); ifu_rvalid = 1; cv("to_err_sticky", 12'b0000_0000_0001);
        // ifu_err with ifu_rvalid: err wins
        do_reset();
        tick(); ifu_rvalid = 1; ifu_err = 1; cv("ifu_err_cycle", 12'b1000_0000_0000);
        tick(); clr(); cv("ifu_err_state", 12'b0000_0000_0001);
        // lsu_err with lsu_rvalid: err wins
        do_reset();
        tick(); ifu_rvalid = 1; dec_dm_rd_sel = 3'd1; dec_rf_wr_en = 1;
        tick(); ifu_rvalid = 0;
        tick(); lsu_rvalid = 1; lsu_err = 1; cv("lsu_err_cycle", 12'b0010_0000_0000);
        tick(); cv("lsu_err_state", 12'b0000_0000_0001);
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/ysyx_exec_ctrl.md
Name: ysyx_exec_ctrl

Overview:
Multi-cycle sequencer for the single-issue RV32 core; drives fetch, decode, memory and writeback phases around the decoder, ALU, register file, CSR file and LSU.
- Consumes the decoder's control outputs.
- Emits per-phase strobes: instruction latch, memory request, rf/csr write enables, pc update and trap entry.
- Owns halt (ebreak) and bus-error/timeout handling.

Parameters:
MEM_TIMEOUT, 255, max wait cycles for an ifu/lsu response before entering ERR (1..2^TW_W-1)
TW_W, 8, width of the wait counter

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
ifu_req  out  1  instruction fetch request, held until ifu_rvalid
ifu_rvalid  in  1  fetch data valid
ifu_err  in  1  fetch bus error
inst_we  out  1  latch fetched instruction into the instruction register
dec_rf_wr_en  in  1  decoder: writes rd
dec_csr_wr_en  in  1  decoder: writes CSR
dec_is_ecall  in  1  decoder: ecall
dec_is_mret  in  1  decoder: mret
dec_is_ebreak  in  1  decoder: ebreak
dec_dm_rd_sel  in  3  decoder: load type, 0 = none
dec_dm_wr_sel  in  2  decoder: store type, 0 = none
lsu_req  out  1  data memory request, held until lsu_rvalid
lsu_we  out  1  store qualifier, valid with lsu_req
lsu_rvalid  in  1  load data valid / store ack
lsu_err  in  1  data bus error
rf_we  out  1  register file write strobe
csr_we  out  1  CSR write strobe
pc_we  out  1  pc register update
pc_sel  out  2  00 next/branch/jump target, 01 mtvec, 10 mepc
trap_we  out  1  write mepc = pc, mcause = 11
halt  out  1  sticky, ebreak reached
err  out  1  sticky, bus error or timeout
perf_cycle  out  64  cycle counter (optional feature)
perf_instret  out  64  retired-instruction counter (optional feature)

Behaviour:
- States: RST, FETCH, DECODE, MEM, WB, TRAP, HALT, ERR. On reset: state RST, all outputs 0, wait counter 0.
- RST -> FETCH unconditionally on the first clock after reset release.
- FETCH:
  - ifu_req=1 every cycle.
  - On ifu_rvalid: inst_we=1 in the same cycle (combinational); -> DECODE.
  - ifu_err -> ERR.
- DECODE (1 cycle):
  - dec_is_ebreak -> HALT.
  - else dec_is_ecall -> TRAP.
  - else dec_dm_rd_sel!=0 or dec_dm_wr_sel!=0 -> MEM.
  - else -> WB.
- MEM:
  - lsu_req=1 every cycle; lsu_we=(dec_dm_wr_sel!=0).
  - On lsu_rvalid -> WB. lsu_err -> ERR.
- WB (1 cycle):
  - rf_we=dec_rf_wr_en; csr_we=dec_csr_wr_en; pc_we=1.
  - pc_sel=10 if dec_is_mret, else 00.
  - -> FETCH.
- TRAP (1 cycle): trap_we=1, pc_we=1, pc_sel=01; -> FETCH.
- HALT: halt=1, all other strobes 0; absorbing until reset.
- ERR: err=1, all other strobes 0; absorbing until reset.
- dec_* inputs are sampled only in DECODE/MEM/WB. They are stable there because the instruction register is written only by inst_we.
- Wait counter:
  - Clears on entry to FETCH or MEM; increments each cycle in those states without a response.
  - When it reaches MEM_TIMEOUT with no response -> ERR.
  - Response in the same cycle the counter hits the limit: response wins.
  - err and rvalid in the same cycle: err wins.
- Minimum latency, zero-wait memory: ALU instruction 3 cycles (FETCH, DECODE, WB); load/store 4 cycles.
- Reset asserted mid-operation: immediate return to RST, all strobes 0 that cycle. No partial write is issued.

Optional Feature:
YSYX_EXEC_CTRL_PERF_EN.
- Defined:
  - perf_cycle increments every cycle after RST, frozen in HALT/ERR.
  - perf_instret increments on each WB or TRAP cycle.
  - Both reset to 0 and wrap modulo 2^64.
- Undefined: both ports tied to 0; no counter flops.

Test Plan:
- Reset release, ALU instruction, ifu_rvalid on 1st FETCH cycle, dec_rf_wr_en=1 -> inst_we at cycle 1, rf_we+pc_we (pc_sel=00) at cycle 3, ifu_req again at cycle 4.
- Load (dec_dm_rd_sel=5), lsu_rvalid after 3 wait cycles -> lsu_req high 4 cycles with lsu_we=0, then one WB cycle with rf_we=1.
- Store (dec_dm_wr_sel=3) -> lsu_we=1 with lsu_req; WB has rf_we=0, pc_we=1.
- ecall -> DECODE then TRAP: trap_we=1, pc_sel=01. mret -> WB with pc_sel=10.
- ebreak -> halt=1 permanently, no further ifu_req. ifu never responds with MEM_TIMEOUT=4 -> err=1 after 4 wait cycles. lsu_rvalid on the limit cycle -> WB, no err.
- Reset pulsed during MEM -> lsu_req drops immediately, FETCH resumes; with PERF_EN, two retired ALU ops -> perf_instret=2.
